// File: rtl/wb_dl11_uart.sv
// rtl/wb_dl11_uart.sv - DL11-style console UART with Wishbone register slave, RX/TX FIFOs and 8N1 serdes

module wb_dl11_uart_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

module wb_dl11_uart #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [1:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rx_irq,
    output logic        tx_irq
);
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic        bus_req, bus_rd, bus_wr;
    logic        rcsr_wr, xcsr_wr, xbuf_wr, rcsr_rd, rbuf_rd;
    logic [15:0] rd_mux;
    logic        ovr, fe, rie, tie, brk;
    logic        ovr_set, fe_set;

    logic        rx_push, rx_empty, rx_full;
    logic [7:0]  rx_head;
    logic        tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_head;

    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev;
    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bitn;
    logic [7:0]  rx_shreg;
    logic        rx_stop_smp;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bitn;
    logic [7:0]  tx_shreg;
    logic        tx_line;

    logic        unused_bits;
    assign unused_bits = ^{wbs_sel_i[1], wbs_dat_i[15:8], wbs_dat_i[5:1]};

    // Every side effect is tied to the cycle that raises the acknowledge.
    assign bus_req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign bus_rd  = bus_req & ~wbs_we_i;
    assign bus_wr  = bus_req & wbs_we_i & wbs_sel_i[0];
    assign rcsr_wr = bus_wr & (wbs_adr_i == 2'd0);
    assign xcsr_wr = bus_wr & (wbs_adr_i == 2'd2);
    assign xbuf_wr = bus_wr & (wbs_adr_i == 2'd3);
    assign rcsr_rd = bus_rd & (wbs_adr_i == 2'd0);
    assign rbuf_rd = bus_rd & (wbs_adr_i == 2'd1);

    always_comb begin
        rd_mux = 16'h0000;
        case (wbs_adr_i)
            2'd0:    rd_mux = {ovr, 1'b0, fe, 5'b0, ~rx_empty, rie, 6'b0};
            2'd1:    rd_mux = {8'h00, rx_empty ? 8'h00 : rx_head};
            2'd2:    rd_mux = {8'h00, ~tx_full, tie, 5'b0, brk};
            default: rd_mux = 16'h0000;
        endcase
    end

    assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == DIV_M1);
    assign rx_push     = rx_stop_smp & rx_s;
    assign fe_set      = rx_stop_smp & ~rx_s;
    assign ovr_set     = rx_push & rx_full & ~rbuf_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 16'h0000;
            ovr       <= 1'b0;
            fe        <= 1'b0;
            rie       <= 1'b0;
            tie       <= 1'b0;
            brk       <= 1'b0;
            rx_irq    <= 1'b0;
            tx_irq    <= 1'b0;
        end else begin
            wbs_ack_o <= bus_req;
            wbs_dat_o <= bus_rd ? rd_mux : 16'h0000;
            if (rcsr_wr) begin
                rie <= wbs_dat_i[6];
            end
            if (xcsr_wr) begin
                tie <= wbs_dat_i[6];
                brk <= wbs_dat_i[0];
            end
            // A new error event in the clearing cycle wins over the clear.
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (rcsr_rd) begin
                ovr <= 1'b0;
            end
            if (fe_set) begin
                fe <= 1'b1;
            end else if (rcsr_rd) begin
                fe <= 1'b0;
            end
            rx_irq <= rie & ~rx_empty;
            tx_irq <= tie & ~tx_full;
        end
    end

    wb_dl11_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rbuf_rd),
        .wdata (rx_shreg),
        .rdata (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    wb_dl11_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (xbuf_wr),
        .pop   (tx_pop),
        .wdata (wbs_dat_i[7:0]),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    // Loading straight from STOP keeps back-to-back frames gapless.
    assign tx_pop = ~tx_empty & ((tx_state == TX_IDLE) ||
                                 ((tx_state == TX_STOP) && (tx_cnt == DIV_M1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'h0000;
            tx_bitn  <= 3'd0;
            tx_shreg <= 8'h00;
            tx_line  <= 1'b1;
        end else begin
            tx_line <= (tx_state == TX_START) ? 1'b0 :
                       (tx_state == TX_DATA)  ? tx_shreg[0] : 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= 16'h0000;
                    if (!tx_empty) begin
                        tx_state <= TX_START;
                        tx_shreg <= tx_head;
                    end
                end
                TX_START: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt   <= 16'h0000;
                        tx_bitn  <= 3'd0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt   <= 16'h0000;
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                        tx_bitn  <= tx_bitn + 3'd1;
                        if (tx_bitn == 3'd7) begin
                            tx_state <= TX_STOP;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt <= 16'h0000;
                        if (!tx_empty) begin
                            tx_state <= TX_START;
                            tx_shreg <= tx_head;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign uart_tx = tx_line & ~brk;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'h0000;
            rx_bitn  <= 3'd0;
            rx_shreg <= 8'h00;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_s;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= 16'h0000;
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt  <= 16'h0000;
                        rx_bitn <= 3'd0;
                        // A start bit that is already high again at mid-bit is a glitch.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt   <= 16'h0000;
                        rx_shreg <= {rx_s, rx_shreg[7:1]};
                        rx_bitn  <= rx_bitn + 3'd1;
                        if (rx_bitn == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt   <= 16'h0000;
                        rx_state <= rx_s ? RX_IDLE : RX_WAIT;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_WAIT: begin
                    if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_dl11_uart.md
# wb_dl11_uart

Parametrised DL11-style console UART: a Wishbone slave with four word registers at 177560–177566 (RCSR, RBUF, XCSR, XBUF), receive and transmit FIFOs, an internal 8N1 serialiser and deserialiser, and interrupt request outputs. It replaces the current ad-hoc terminal port, which has no buffering, no interrupts and a non-standard status layout. It connects to the CPU master bus and to the vm_irq/virq logic of the mini top.

## Interface
- CLK_DIV, 434: clk cycles per serial bit, range 4..65535 (434 gives 115200 baud at 50 MHz).
- FIFO_AW, 4: log2 of the FIFO depth; RX and TX FIFOs each hold 2^FIFO_AW bytes (FIFO_AW 1..8).
- clk  in  1  system clock; every register in the block is clocked on its rising edge.
- reset  in  1  asynchronous active-low reset.
- wbs_adr_i  in  2  word select, driven from address bits [2:1]: 0=RCSR, 1=RBUF, 2=XCSR, 3=XBUF.
- wbs_dat_i  in  16  write data.
- wbs_dat_o  out  16  read data; valid while wbs_ack_o is high, 0 otherwise.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe and write enable.
- wbs_sel_i  in  2  byte lanes; only lane 0 (bits 7:0) is significant.
- wbs_ack_o  out  1  acknowledge.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output; idles high.
- rx_irq, tx_irq  out  1 each  level interrupt requests.

## Operation
- Register map (bits not listed read 0; writes to them are ignored):
  - RCSR bit15 OVR: sticky.
  - RCSR bit13 FE: sticky.
  - RCSR bit7 DONE: read-only, set when the RX FIFO is not empty.
  - RCSR bit6 RIE: read/write.
  - RBUF bits7:0 hold the RX FIFO head (0 when the FIFO is empty). A read pops one byte when the FIFO is not empty.
  - XCSR bit7 RDY: read-only, set when the TX FIFO is not full.
  - XCSR bit6 TIE: read/write.
  - XCSR bit0 BRK: read/write; while set, uart_tx is held low.
  - XBUF: a write with sel[0]=1 pushes wbs_dat_i[7:0]. A write while the FIFO is full is dropped silently. Reads of XBUF return 0.
- Reading RCSR clears OVR and FE in the acknowledge cycle; the returned value still shows the bits as they were before clearing.
- A write to RCSR or XCSR with sel[0]=0 changes nothing.
- rx_irq = RIE & DONE and tx_irq = TIE & RDY, both registered (one cycle behind the underlying state).
- TX state machine: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE. Each state lasts CLK_DIV cycles. The machine leaves IDLE only when the TX FIFO is not empty; it pops the FIFO in that cycle and drives the start bit on the next cycle.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - States: IDLE -> START -> DATA -> STOP -> IDLE.
  - A falling edge in IDLE starts the START state. The line is sampled at CLK_DIV/2 (integer division). If it is high there, the machine returns to IDLE as a glitch and pushes nothing.
  - Data bits are sampled at mid-bit, every CLK_DIV cycles.
  - If the stop-bit sample is 1, the byte is pushed. If it is 0, FE is set, the byte is discarded, and the machine waits for the line to go high before returning to IDLE.
- Overflow: if the RX FIFO is full when a byte completes, the byte is dropped and OVR is set. If a pop lands in the same cycle as the push, both happen and OVR is not set.
- FIFOs: circular buffers with FIFO_AW-bit pointers that wrap modulo 2^FIFO_AW, plus an occupancy count of FIFO_AW+1 bits. A simultaneous push and pop is always legal, including when the FIFO is full and when it is empty; when empty, the pop is a no-op and the push succeeds.

## Timing
- Reset values:
  - Outputs: uart_tx=1, wbs_ack_o=0, wbs_dat_o=0, rx_irq=0, tx_irq=0.
  - Registers: OVR, FE, RIE, TIE and BRK all 0.
  - Both FIFOs empty. Both state machines in IDLE. The synchroniser flops are preset to 1.
- Handshake:
  - wbs_ack_o rises one cycle after the first cycle in which wbs_cyc_i & wbs_stb_i & !wbs_ack_o holds.
  - It stays high for exactly one cycle, so back-to-back strobes are acknowledged every second cycle.
  - Write data, pushes and pops, and register side effects all take effect on the acknowledge edge, exactly once per access.
  - If wbs_cyc_i drops before the acknowledge, no side effect occurs.
- Read data is registered and presented in the same cycle as wbs_ack_o.
- XBUF write to first line activity: with the FIFO empty and TX idle, the start bit appears 2 cycles after the acknowledge edge.
- Serial frame: exactly 10*CLK_DIV cycles. Back-to-back frames have no idle gap between STOP and the next START.
- Receive latency: the byte becomes visible in DONE and RBUF 1 cycle after the stop-bit sample; rx_irq follows one cycle later.
- BRK overrides the serialiser output immediately after its write, but does not pause the TX state machine.
- Asserting reset mid-frame immediately returns uart_tx to 1 and clears everything listed under reset values.

## Test plan
- Reset: hold reset low, then release -> uart_tx=1, RCSR reads 0x0000, XCSR reads 0x0080, no irqs.
- TX (CLK_DIV=8): write 0x0055 to XBUF -> start bit 2 cycles after the acknowledge, then 1,0,1,0,1,0,1,0, stop bit; frame lasts 80 cycles; RDY stays 1.
- RX: drive 0xA3 at CLK_DIV=8 -> RCSR bit7=1, RBUF reads 0x00A3, then RCSR bit7=0; with RIE=1, rx_irq goes high and then drops after the read.
- Overflow (FIFO_AW=2): receive 5 bytes 0x01..0x05 with no reads -> RCSR=0x8080, RBUF returns 01,02,03,04; the second RCSR read shows OVR=0.
- Framing error: drive 0x3C with a stop bit of 0 -> FE set, FIFO stays empty; a clean byte after the line returns high is received normally.
- TX FIFO full (FIFO_AW=2): 6 writes back-to-back -> RDY=0 after the fifth write (one byte has moved into the shifter), the sixth write is dropped; exactly 5 frames are observed; tx_irq with TIE=1 reasserts once space opens.
